// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front-end fetch stage that sits directly upstream of decode. It owns the PC
// and issues in-order word reads to instruction memory. Returned words are
// buffered together with their PC and handed to decode over a valid/ready
// handshake. A redirect from execute restarts fetch at a new PC. Words that are
// already buffered, or still in flight, are flushed.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect whose target has bits [1:0] != 0 raises the sticky
//               fetchMisaligned flag and halts fetch. The next aligned redirect
//               (or reset) clears the flag and resumes fetch.
//   undefined : target bits [1:0] are forced to zero, fetchMisaligned stays 0
//               and the HALT state is unreachable.
//
// Ports
//   clk, rst                       clock; synchronous active-high reset
//   imemReqValid/Ready/Addr        fetch request to instruction memory
//   imemRespValid/Data             in-order response words
//   instValid/Ready/Data/Pc        instruction and its PC, presented to decode
//   redirectValid/redirectPc       redirect pulse and its target, from execute
//   fetchMisaligned                sticky misaligned-target flag
// -----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;
  typedef logic [31:0] instruction_t;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HALT} fetch_state_t;
endpackage

module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2,
  parameter int              MAX_OUTST  = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imemReqValid,
  input  logic               imemReqReady,
  output logic [XLEN-1:0]    imemReqAddr,
  input  logic               imemRespValid,
  input  logic [31:0]        imemRespData,
  output logic               instValid,
  input  logic               instReady,
  output instruction_t       instData,
  output logic [XLEN-1:0]    instPc,
  input  logic               redirectValid,
  input  logic [XLEN-1:0]    redirectPc,
  output logic               fetchMisaligned
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  // One common width for all counters. It is wide enough to hold count+outst,
  // which can be at most 2*FIFO_DEPTH.
  localparam int CW = AW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTST);
  localparam logic [QW-1:0] Q_LAST  = QW'(MAX_OUTST - 1);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;

  // Instruction buffer: circular, power-of-two depth.
  instruction_t    buf_data [FIFO_DEPTH];
  logic [XLEN-1:0] buf_pc   [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  // PCs of accepted requests that are still waiting for a response. Responses
  // return in order, so this is a simple FIFO that runs in step with outst.
  logic [XLEN-1:0] pcq [MAX_OUTST];
  logic [QW-1:0]   q_rd, q_wr;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   discard;

  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            pop_raw, pop, req_fire, resp_fire, resp_keep;
  logic [CW-1:0]   eff_count;

  // PC always stays word aligned. Only the trap build looks at the low bits.
  assign target = redirectPc & ~XLEN'(3);
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = (redirectPc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign instValid = (count != '0);
  assign instData  = buf_data[rd_ptr];
  assign instPc    = buf_pc[rd_ptr];

  assign pop_raw   = instValid & instReady;
  assign pop       = pop_raw & ~redirectValid;
  // The credit check counts the entry that decode frees in this cycle. This
  // lets a 2-entry buffer with 1-cycle memory sustain one instruction per
  // cycle.
  assign eff_count = count - CW'(pop_raw);

  assign imemReqValid = (state == ST_FETCH) && ((eff_count + outst) < DEPTH_C) &&
                        (outst < MAX_C) && !redirectValid;
  assign imemReqAddr  = pc;

  assign req_fire  = imemReqValid & imemReqReady;
  // A response that arrives with nothing outstanding is a protocol error and
  // is ignored.
  assign resp_fire = imemRespValid && (outst != '0);
  assign resp_keep = resp_fire && (discard == '0) && !redirectValid;

  // NOTE: every register here is written with <= so that all of them update
  // together on the edge, whatever order the statements are listed in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      pc              <= RESET_PC;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      q_rd            <= '0;
      q_wr            <= '0;
      outst           <= '0;
      discard         <= '0;
      fetchMisaligned <= 1'b0;
    end else begin
      outst <= outst + CW'(req_fire) - CW'(resp_fire);

      if (req_fire) begin
        pcq[q_wr] <= pc;
        q_wr      <= (q_wr == Q_LAST) ? '0 : q_wr + QW'(1);
        pc        <= pc + XLEN'(4);
      end
      // Every response retires its queue entry, including discarded ones.
      if (resp_fire) q_rd <= (q_rd == Q_LAST) ? '0 : q_rd + QW'(1);

      if (redirectValid) begin
        // req_fire is gated off here, so only the responses still outstanding
        // after this cycle are owed to the old path.
        pc      <= target;
        count   <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        discard <= outst - CW'(resp_fire);
        if (misaligned) begin
          state           <= ST_HALT;
          fetchMisaligned <= 1'b1;
        end else begin
          state           <= ST_FETCH;
          fetchMisaligned <= 1'b0;
        end
      end else begin
        if (resp_fire && (discard != '0)) discard <= discard - CW'(1);
        // NOTE: the buffer storage is deliberately left out of reset. Entries
        // are only read while count marks them valid.
        if (resp_keep) begin
          buf_data[wr_ptr] <= imemRespData;
          buf_pc[wr_ptr]   <= pcq[q_rd];
          wr_ptr           <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(resp_keep) - CW'(pop);
        if (state == ST_IDLE) state <= ST_FETCH;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Self-checking bench for instruction_fetch_unit (XLEN=64, RESET_PC=0x1000,
// FIFO_DEPTH=2, MAX_OUTST=2).
// - Memory model: an in-order responder with a configurable latency.
// - Scoreboard: the bench keeps its own model of the fetch PC. Each accepted
//   request checks the address against that model and pushes the expected
//   {pc, word} into a queue. Each instruction that decode accepts is popped
//   from the queue and compared. A redirect flushes the queue.
// - Redirect cases run from a table of vectors; the multi-cycle corner cases
//   are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic         clk = 1'b0;
  logic         rst;
  logic         imemReqValid, imemReqReady;
  logic [63:0]  imemReqAddr;
  logic         imemRespValid;
  logic [31:0]  imemRespData;
  logic         instValid, instReady;
  instruction_t instData;
  logic [63:0]  instPc;
  logic         redirectValid;
  logic [63:0]  redirectPc;
  logic         fetchMisaligned;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .XLEN(64), .RESET_PC(RST_PC), .FIFO_DEPTH(2), .MAX_OUTST(2)
  ) dut (
    .clk(clk), .rst(rst),
    .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .instValid(instValid), .instReady(instReady), .instData(instData), .instPc(instPc),
    .redirectValid(redirectValid), .redirectPc(redirectPc),
    .fetchMisaligned(fetchMisaligned)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  // ---------------- memory model ----------------
  typedef struct { logic [63:0] addr; int due; } mem_req_t;
  mem_req_t mq[$];
  int cyc = 0;
  int mem_lat = 1;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      imemRespValid <= 1'b0;
      imemRespData  <= '0;
    end else begin
      if (imemReqValid && imemReqReady) mq.push_back('{imemReqAddr, cyc + mem_lat - 1});
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imemRespValid <= 1'b1;
        imemRespData  <= mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imemRespValid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct { logic [63:0] pc; logic [31:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [63:0] mpc;
  logic [63:0] last_pc;
  int          fires = 0;
  int          consumed = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mpc = RST_PC;
    end else begin
      if (instValid && instReady && !redirectValid) begin
        check("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("inst_pc", instPc, e.pc);
          check("inst_data", 64'(instData), 64'(e.data));
        end
        consumed++;
        last_pc = instPc;
      end
      if (imemReqValid && imemReqReady) begin
        check("req_addr", imemReqAddr, mpc);
        exp_q.push_back('{mpc, mem_word(mpc)});
        mpc = mpc + 64'd4;
        fires++;
      end
      if (redirectValid) begin
        check("req_gated_by_redirect", 64'(imemReqValid), 64'd0);
        exp_q.delete();
        mpc = redirectPc & ~64'h3;
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [63:0] target;
    int          lat;
    int          n;
    logic [63:0] first_pc;
    logic [63:0] last_pc;
  } vec_t;
  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_consumed(input int n, input string name);
    int k = 0;
    while (consumed < n && k < 200) begin
      tick();
      k++;
    end
    check(name, 64'(consumed >= n), 64'd1);
  endtask

  task automatic redirect(input logic [63:0] t);
    redirectValid = 1'b1;
    redirectPc    = t;
    tick();
    redirectValid = 1'b0;
  endtask

  int c0, f0, k;

  initial begin
    vecs[0] = '{64'h2000,                1, 8, 64'h2000,                64'h201C};
    vecs[1] = '{64'h40,                  2, 5, 64'h40,                  64'h50};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFF8, 1, 4, 64'hFFFF_FFFF_FFFF_FFF8, 64'h4};
    vecs[3] = '{64'h1234_5678_9ABC_DEF0, 3, 3, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF8};

    rst = 1'b1; imemReqReady = 1'b1; instReady = 1'b1;
    redirectValid = 1'b0; redirectPc = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_req_valid", 64'(imemReqValid), 64'd0);
    check("rst_inst_valid", 64'(instValid), 64'd0);
    check("rst_misaligned", 64'(fetchMisaligned), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_req", 64'(imemReqValid), 64'd0);
    tick();
    @(negedge clk);
    check("first_req_valid", 64'(imemReqValid), 64'd1);
    check("first_req_addr", imemReqAddr, RST_PC);
    tick();

    // Steady-state streaming: one instruction per cycle.
    k = 0;
    while (!instValid && k < 20) begin tick(); k++; end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stream_one_per_cycle", 64'(instValid), 64'd1);
    end
    tick();

    // Decode stalls: the buffer fills and requests stop.
    instReady = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("full_no_req", 64'(imemReqValid), 64'd0);
    check("full_inst_valid", 64'(instValid), 64'd1);
    tick();
    imemReqReady = 1'b0;
    instReady    = 1'b1;
    c0 = consumed;
    repeat (6) tick();
    check("buffered_words", 64'(consumed - c0), 64'd2);
    // Memory not ready: the address is held and the PC does not advance.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("addr_held", imemReqAddr, mpc);
      check("req_valid_held", 64'(imemReqValid), 64'd1);
    end
    check("drained_inst_valid", 64'(instValid), 64'd0);
    tick();
    check("drained_sb", 64'(exp_q.size()), 64'd0);

    // Two requests in flight, then a redirect: both late words are dropped.
    mem_lat = 3;
    f0 = fires;
    imemReqReady = 1'b1;
    k = 0;
    while (fires < f0 + 2 && k < 20) begin tick(); k++; end
    imemReqReady = 1'b0;
    check("two_outstanding", 64'(mq.size()), 64'd2);
    c0 = consumed;
    imemReqReady = 1'b1;
    redirect(64'h2000);
    @(negedge clk);
    check("flush_inst_valid", 64'(instValid), 64'd0);
    tick();
    wait_consumed(c0 + 1, "redirect_timeout");
    check("redirect_first_pc", last_pc, 64'h2000);
    mem_lat = 1;

    // Back-to-back redirects: the last one wins.
    c0 = consumed;
    redirectValid = 1'b1; redirectPc = 64'h5000; tick();
    redirectPc = 64'h6000; tick();
    redirectValid = 1'b0;
    wait_consumed(c0 + 1, "b2b_timeout");
    check("b2b_first_pc", last_pc, 64'h6000);

    // Table-driven redirects issued while streaming, including the PC wrap.
    for (int i = 0; i < 4; i++) begin
      mem_lat = vecs[i].lat;
      c0 = consumed;
      redirect(vecs[i].target);
      wait_consumed(c0 + 1, "vec_first_timeout");
      check("vec_first_pc", last_pc, vecs[i].first_pc);
      wait_consumed(c0 + vecs[i].n, "vec_last_timeout");
      check("vec_last_pc", last_pc, vecs[i].last_pc);
    end
    mem_lat = 1;

    // Misaligned redirect target.
    c0 = consumed;
    redirect(64'h2002);
`ifdef FETCH_MISALIGN_TRAP_EN
    @(negedge clk);
    check("misalign_flag_set", 64'(fetchMisaligned), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halt_no_req", 64'(imemReqValid), 64'd0);
    end
    tick();
    c0 = consumed;
    redirect(64'h3000);
    @(negedge clk);
    check("misalign_flag_clear", 64'(fetchMisaligned), 64'd0);
    tick();
    wait_consumed(c0 + 1, "resume_timeout");
    check("resume_pc", last_pc, 64'h3000);
`else
    @(negedge clk);
    check("misalign_flag_off", 64'(fetchMisaligned), 64'd0);
    tick();
    wait_consumed(c0 + 1, "misalign_off_timeout");
    check("misalign_off_pc", last_pc, 64'h2000);
`endif

    // Reset in the middle of streaming; the memory model is reset with it.
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("midrst_inst_valid", 64'(instValid), 64'd0);
    check("midrst_req_valid", 64'(imemReqValid), 64'd0);
    tick();
    rst = 1'b0;
    c0 = consumed;
    wait_consumed(c0 + 1, "restart_timeout");
    check("restart_pc", last_pc, RST_PC);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
